diff_decode_serial: RTL and testbench
=====================================

DIFF_DECODE_SERIAL -- requirements
Module: diff_decode_serial

Interface
REQ-001 Parameter N, default 100: digits per word; each digit is 2 bits; N >= 2.
REQ-002 Parameter DPC, default 4: digits decoded per clock; N % DPC == 0 SHALL hold; 1 <= DPC <= N.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  word_in is valid this cycle.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 word_in  input  2*N  differential word; digit i occupies bits [2i+1:2i]; digit N-1 is leftmost.
REQ-008 out_valid  output  1  word_out holds a completed decode.
REQ-009 out_ready  input  1  consumer accepts word_out this cycle.
REQ-010 word_out  output  2*N  decoded (original) word, same digit layout as word_in.
REQ-011 busy  output  1  high while decoding is in progress.
REQ-012 word_count  output  16  number of words handed off; saturates at 0xFFFF.

Function
REQ-013 Decode rule: out[N-1] = in[N-1]; out[i] = (in[i] + out[i+1]) mod 4 for i = N-2 down to 0. This is the exact inverse of the differential encoder stage.
REQ-014 Mod-4 addition SHALL be 2-bit wrap-around; the carry out of bit 1 is discarded, e.g. 3+2 = 1.
REQ-015 FSM states: IDLE, BUSY, DONE. In IDLE, in_ready = 1. In BUSY and DONE, in_ready = 0.
REQ-016 IDLE -> BUSY on an edge with in_valid && in_ready; word_in SHALL be captured into an internal register on that edge.
REQ-016a The BUSY-entry edge SHALL also clear the running accumulator to 0 and the group counter to 0. word_in may change after the capture edge.
REQ-017 Each BUSY edge SHALL decode one group of DPC digits, in MSB-first order: group g covers digits N-1-g*DPC down to N-g*DPC-DPC.
REQ-017a Within a group, digits SHALL be chained combinationally, and the accumulator SHALL be updated to the lowest digit of the group.
REQ-018 The group counter SHALL increment once per BUSY edge. On the edge that decodes group N/DPC-1, the FSM SHALL go BUSY -> DONE.
REQ-019 Latency: out_valid SHALL rise exactly N/DPC edges after the accepting edge. For example, with N=100 and DPC=4 this is 25 edges.
REQ-020 In DONE, out_valid = 1, and word_out SHALL be the full decoded word.
REQ-020a word_out and out_valid SHALL remain stable while out_ready = 0, for any number of cycles.
REQ-021 DONE -> IDLE on an edge with out_valid && out_ready. word_count SHALL increment on that same edge unless it is already 0xFFFF.
REQ-022 word_out SHALL hold its last value after handoff until the next decode overwrites it.
REQ-022a word_out SHALL be registered, and SHALL be 0 only after reset.
REQ-023 busy = 1 exactly in state BUSY; out_valid = 1 exactly in state DONE.
REQ-024 in_valid asserted while in_ready = 0 SHALL be ignored, with no capture and no state change.
REQ-025 Simultaneous in_valid and out_ready in DONE: only the handoff occurs. A new word SHALL NOT be accepted until the following IDLE cycle, so there is one bubble cycle per word.
REQ-026 Throughput: at most one word per N/DPC + 2 cycles.

Reset
REQ-027 While rst = 1 at an edge, that edge SHALL force: state = IDLE, out_valid = 0, busy = 0, in_ready = 1 (from the next cycle), word_out = 0, word_count = 0, accumulator = 0, group counter = 0.
REQ-028 Reset SHALL take priority over every handshake. If reset is applied mid-BUSY or in DONE, the in-flight word SHALL be discarded and never presented.
REQ-029 No output SHALL be X after the first reset edge.

Verification (bench parameters: N=8, DPC=2; latency 4 edges)
REQ-030 word_in = 0x5555 (all digits 1) -> out_valid 4 edges after acceptance; word_out = 0x6C6C (digits 1,2,3,0,1,2,3,0).
REQ-031 word_in = 0xFFFF -> word_out = 0xE4E4. word_in = 0x0000 -> word_out = 0x0000. word_count = 2 after both handoffs.
REQ-032 Back-pressure: hold out_ready = 0 for 10 cycles in DONE -> out_valid stays 1, word_out is unchanged, and in_ready = 0. Pulsing in_valid during this period is ignored.
REQ-033 Reset mid-decode: assert rst on the 2nd BUSY edge -> next cycle state IDLE, out_valid = 0, word_out = 0, word_count = 0, in_ready = 1.
REQ-033a After the mid-decode reset, a new word SHALL decode correctly.
REQ-034 Round trip: 1000 random 16-bit words through the differential encoder and then this block -> each word_out equals the original word.
REQ-034a Repeat the round trip with random out_ready stalls.
REQ-034b Repeat with DPC = 1, 4 and 8 (N = 8).

Source files
------------

// File: rtl/diff_decode_serial.sv
// Serial differential decoder: undoes mod-4 differential encoding of an N-digit word,
// DPC digits per clock, most significant digit first.
module diff_decode_serial #(
    parameter int unsigned N   = 100,
    parameter int unsigned DPC = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] word_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] word_out,
    output logic           busy,
    output logic [15:0]    word_count
);
    localparam int unsigned Groups = N / DPC;
    localparam int unsigned GrpW   = (Groups > 1) ? $clog2(Groups) : 1;
    localparam logic [GrpW-1:0] LastGrp = GrpW'(Groups - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [2*N-1:0]  src_q, src_d;     // captured word, shifted left one group per BUSY edge
    logic [2*N-1:0]  dec_q, dec_d;     // partial result, groups shifted in from the right
    logic [2*N-1:0]  out_q, out_d;
    logic [1:0]      acc_q, acc_d;
    logic [GrpW-1:0] grp_q, grp_d;
    logic [15:0]     count_q, count_d;

    logic [1:0]      run;
    logic [2*N-1:0]  grp_ext;

    // Chain the DPC digits at the top of src_q onto the running accumulator.
    always_comb begin
        run     = acc_q;
        grp_ext = '0;
        for (int j = 0; j < int'(DPC); j++) begin
            run = run + src_q[2*N-1-2*j -: 2];
            grp_ext[2*(DPC-1-j) +: 2] = run;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dec_d   = dec_q;
        out_d   = out_q;
        acc_d   = acc_q;
        grp_d   = grp_q;
        count_d = count_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StBusy;
                    src_d   = word_in;
                    acc_d   = '0;
                    grp_d   = '0;
                end
            end
            StBusy: begin
                src_d = src_q << (2*DPC);
                dec_d = (dec_q << (2*DPC)) | grp_ext;
                acc_d = run;
                grp_d = grp_q + GrpW'(1);
                if (grp_q == LastGrp) begin
                    state_d = StDone;
                    out_d   = dec_d;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            src_q   <= '0;
            dec_q   <= '0;
            out_q   <= '0;
            acc_q   <= '0;
            grp_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dec_q   <= dec_d;
            out_q   <= out_d;
            acc_q   <= acc_d;
            grp_q   <= grp_d;
            count_q <= count_d;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign busy       = (state_q == StBusy);
    assign out_valid  = (state_q == StDone);
    assign word_out   = out_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_diff_decode_serial.sv
// Directed and round-trip bench for diff_decode_serial, N=8, with DPC = 2, 1, 4 and 8
// instances driven independently.
module tb_diff_decode_serial;
    localparam int unsigned N = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_a   [4];
    logic        in_ready_a   [4];
    logic [15:0] word_in_a    [4];
    logic        out_valid_a  [4];
    logic        out_ready_a  [4];
    logic [15:0] word_out_a   [4];
    logic        busy_a       [4];
    logic [15:0] word_count_a [4];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned D = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 8;
        diff_decode_serial #(
            .N   (N),
            .DPC (D)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid_a[g]),
            .in_ready   (in_ready_a[g]),
            .word_in    (word_in_a[g]),
            .out_valid  (out_valid_a[g]),
            .out_ready  (out_ready_a[g]),
            .word_out   (word_out_a[g]),
            .busy       (busy_a[g]),
            .word_count (word_count_a[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Differential encoder: e[N-1] = w[N-1], e[i] = w[i] - w[i+1] mod 4.
    function automatic logic [15:0] enc(input logic [15:0] w);
        logic [15:0] e;
        e[15:14] = w[15:14];
        for (int i = 0; i < 7; i++) e[2*i +: 2] = w[2*i +: 2] - w[2*i+2 +: 2];
        return e;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid_a[k]  = 1'b0;
            out_ready_a[k] = 1'b0;
            word_in_a[k]   = 16'h0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send(input int k, input logic [15:0] w);
        int c = 0;
        while (!in_ready_a[k] && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        if (!in_ready_a[k]) check("send_ready", {31'd0, in_ready_a[k]}, 32'd1);
        in_valid_a[k] = 1'b1;
        word_in_a[k]  = w;
        @(posedge clk); #1;
        in_valid_a[k] = 1'b0;
        word_in_a[k]  = 16'($urandom);
    endtask

    task automatic wait_valid(input int k, output int lat);
        lat = 0;
        while (!out_valid_a[k] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic get(input int k, input bit stall, output logic [15:0] r, output bit ok);
        logic rdy;
        ok = 1'b0;
        r  = 16'h0;
        for (int c = 0; c < 200 && !ok; c++) begin
            rdy = (stall && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            out_ready_a[k] = rdy;
            r  = word_out_a[k];
            ok = out_valid_a[k] && rdy;
            @(posedge clk); #1;
        end
        out_ready_a[k] = 1'b0;
    endtask

    task automatic round_trip(input int k, input bit stall);
        logic [15:0] w, r;
        bit ok;
        for (int i = 0; i < 1000; i++) begin
            w = 16'($urandom);
            send(k, enc(w));
            get(k, stall, r, ok);
            if (!ok) check($sformatf("rt%0d_timeout", k), {31'd0, ok}, 32'd1);
            else check($sformatf("rt%0d_word", k), {16'd0, r}, {16'd0, w});
        end
    endtask

    initial begin
        int          lat;
        logic [15:0] r;
        bit          ok;

        do_reset();
        check("rst_in_ready",  {31'd0, in_ready_a[0]},  32'd1);
        check("rst_out_valid", {31'd0, out_valid_a[0]}, 32'd0);
        check("rst_busy",      {31'd0, busy_a[0]},      32'd0);
        check("rst_word_out",  {16'd0, word_out_a[0]},  32'h0);
        check("rst_count",     {16'd0, word_count_a[0]}, 32'h0);

        // All digits 1, with junk on word_in after capture.
        send(0, 16'h5555);
        check("acc_busy",     {31'd0, busy_a[0]},     32'd1);
        check("acc_in_ready", {31'd0, in_ready_a[0]}, 32'd0);
        wait_valid(0, lat);
        check("lat_5555",  lat, 32'd4);
        check("word_5555", {16'd0, word_out_a[0]}, 32'h6C6C);

        // Back-pressure with in_valid pulses that must be ignored.
        for (int i = 0; i < 10; i++) begin
            in_valid_a[0] = i[0];
            word_in_a[0]  = 16'hAAAA;
            @(posedge clk); #1;
            check("bp_out_valid", {31'd0, out_valid_a[0]}, 32'd1);
            check("bp_word_out",  {16'd0, word_out_a[0]},  32'h6C6C);
            check("bp_in_ready",  {31'd0, in_ready_a[0]},  32'd0);
        end

        // Handoff with simultaneous in_valid: only the handoff happens.
        in_valid_a[0]  = 1'b1;
        word_in_a[0]   = 16'h0F0F;
        out_ready_a[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_a[0]  = 1'b0;
        out_ready_a[0] = 1'b0;
        check("ho_out_valid", {31'd0, out_valid_a[0]}, 32'd0);
        check("ho_in_ready",  {31'd0, in_ready_a[0]},  32'd1);
        check("ho_busy",      {31'd0, busy_a[0]},      32'd0);
        check("ho_count",     {16'd0, word_count_a[0]}, 32'd1);
        check("ho_hold",      {16'd0, word_out_a[0]},  32'h6C6C);
        @(posedge clk); #1;
        check("ho_no_accept", {31'd0, busy_a[0]},      32'd0);

        // Reset asserted on the 2nd BUSY edge.
        send(0, 16'h1234);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mr_state_idle", {31'd0, in_ready_a[0]},  32'd1);
        check("mr_out_valid",  {31'd0, out_valid_a[0]}, 32'd0);
        check("mr_busy",       {31'd0, busy_a[0]},      32'd0);
        check("mr_word_out",   {16'd0, word_out_a[0]},  32'h0);
        check("mr_count",      {16'd0, word_count_a[0]}, 32'h0);
        repeat (6) @(posedge clk);
        #1 check("mr_discard", {31'd0, out_valid_a[0]}, 32'd0);
        send(0, 16'h5555);
        wait_valid(0, lat);
        check("mr_lat",  lat, 32'd4);
        check("mr_word", {16'd0, word_out_a[0]}, 32'h6C6C);

        do_reset();
        send(0, 16'hFFFF);
        wait_valid(0, lat);
        check("lat_ffff", lat, 32'd4);
        get(0, 1'b0, r, ok);
        check("get_ffff_ok", {31'd0, ok}, 32'd1);
        check("word_ffff",   {16'd0, r},  32'hE4E4);
        send(0, 16'h0000);
        wait_valid(0, lat);
        check("word_0000_pre", {16'd0, word_out_a[0]}, 32'h0000);
        get(0, 1'b0, r, ok);
        check("get_0000_ok", {31'd0, ok}, 32'd1);
        check("count_two",   {16'd0, word_count_a[0]}, 32'd2);

        // Latency of the other widths: N/DPC edges.
        send(1, 16'h5555);
        wait_valid(1, lat);
        check("lat_dpc1", lat, 32'd8);
        check("word_dpc1", {16'd0, word_out_a[1]}, 32'h6C6C);
        send(3, 16'hFFFF);
        wait_valid(3, lat);
        check("lat_dpc8", lat, 32'd1);
        check("word_dpc8", {16'd0, word_out_a[3]}, 32'hE4E4);

        do_reset();
        fork
            round_trip(0, 1'b0);
            round_trip(1, 1'b0);
            round_trip(2, 1'b0);
            round_trip(3, 1'b0);
        join
        fork
            round_trip(0, 1'b1);
            round_trip(1, 1'b1);
            round_trip(2, 1'b1);
            round_trip(3, 1'b1);
        join

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
